// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART pair: parity modes,
// frame state encoding and a constant-evaluable clog2 helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Ceiling log2, usable in parameter and port width expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the transmitter. The head word is always
// visible on pop_data so the consumer can load it on the same edge it pops.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;

    // Storage write; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered words are framed as
// start, DATA_BITS data (LSB first), optional parity and STOP_BITS stop bits.
module uart_tx_param import uart_pkg::*; #(
    parameter int CLOCK_HZ   = 10_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_BITS-1:0]        data_in,
    input  logic                        data_valid,
    output logic                        data_ready_o,
    output logic [clog2(FIFO_DEPTH):0]  fifo_count_o,
    output logic                        busy_o,
    output logic                        bits
);

    localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
    localparam int BAUD_W       = clog2(CLKS_PER_BIT);
    localparam int IDX_W        = clog2(DATA_BITS);

    uart_state_e          state_reg, state_next;
    logic [BAUD_W-1:0]    baud_reg, baud_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic                 stop_reg, stop_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic                 bits_reg, bits_next;

    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 head_parity;
    logic                 baud_last;
    logic                 idx_last;
    logic                 stop_last;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (data_valid),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_o)
    );

    assign data_ready_o = !fifo_full;
    assign busy_o       = (state_reg != ST_IDLE);
    assign bits         = bits_reg;

    // Parity is fixed when the word is loaded, so it is ready long before use.
    assign head_parity = (^fifo_head) ^ (PARITY == PAR_ODD);

    assign baud_last = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));
    assign idx_last  = (idx_reg == IDX_W'(DATA_BITS - 1));
    assign stop_last = (stop_reg == 1'(STOP_BITS - 1));

    // Frame sequencing; the line level is derived from the state being entered
    // so the registered output changes on the same edge as the state.
    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg + BAUD_W'(1);
        idx_next    = idx_reg;
        stop_next   = stop_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        pop         = 1'b0;
        bits_next   = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    state_next = ST_DATA;
                    baud_next  = '0;
                    idx_next   = '0;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (idx_last) begin
                        state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        stop_next  = 1'b0;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    state_next = ST_STOP;
                    baud_next  = '0;
                    stop_next  = 1'b0;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (stop_last) begin
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            state_next = ST_START;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        stop_next = stop_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                baud_next  = '0;
            end
        endcase

        if (pop) begin
            shift_next  = fifo_head;
            parity_next = head_parity;
        end

        case (state_next)
            ST_START:  bits_next = 1'b0;
            ST_DATA:   bits_next = shift_next[0];
            ST_PARITY: bits_next = parity_next;
            default:   bits_next = 1'b1;
        endcase
    end

    // State, counters, shift register and line output; reset abandons any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            baud_reg   <= '0;
            idx_reg    <= '0;
            stop_reg   <= 1'b0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            bits_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            idx_reg    <= idx_next;
            stop_reg   <= stop_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            bits_reg   <= bits_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations (8N1, 7E2, 8O1) at 10 clocks
// per bit, a per-cycle frame-level reference model, a table of known frames
// and hand-written FIFO-burst / reset / idle sequences.
module tb_uart_tx_param;

    localparam int C     = 10;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] din0;
    logic [6:0] din1;
    logic [7:0] din2;
    logic       v0, v1, v2;
    logic       rdy0, rdy1, rdy2;
    logic [2:0] cnt0, cnt1, cnt2;
    logic       busy0, busy1, busy2;
    logic       line0, line1, line2;

    int checks = 0;
    int fails  = 0;

    uart_tx_param #(.CLOCK_HZ(10_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
        .clk(clk), .rst_n(rst_n), .data_in(din0), .data_valid(v0),
        .data_ready_o(rdy0), .fifo_count_o(cnt0), .busy_o(busy0), .bits(line0));

    uart_tx_param #(.CLOCK_HZ(10_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u1 (
        .clk(clk), .rst_n(rst_n), .data_in(din1), .data_valid(v1),
        .data_ready_o(rdy1), .fifo_count_o(cnt1), .busy_o(busy1), .bits(line1));

    uart_tx_param #(.CLOCK_HZ(10_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u2 (
        .clk(clk), .rst_n(rst_n), .data_in(din2), .data_valid(v2),
        .data_ready_o(rdy2), .fifo_count_o(cnt2), .busy_o(busy2), .bits(line2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int id, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s inst=%0d t=%0t got=%0d expected=%0d", name, id, $time, got, exp);
        end
    endtask

    // ---------------- configuration and frame rules ----------------
    function automatic int cfg_db(input int id);
        return (id == 1) ? 7 : 8;
    endfunction
    function automatic int cfg_par(input int id);
        return id;              // 0 none, 1 even, 2 odd
    endfunction
    function automatic int cfg_sb(input int id);
        return (id == 1) ? 2 : 1;
    endfunction
    function automatic int flen(input int id);
        return (1 + cfg_db(id) + ((cfg_par(id) != 0) ? 1 : 0) + cfg_sb(id)) * C;
    endfunction
    // Line level of bit slot idx of the frame carrying word w.
    function automatic int frame_bit(input int id, input int w, input int idx);
        int db, par, ones;
        db  = cfg_db(id);
        par = cfg_par(id);
        if (idx == 0) return 0;
        if (idx <= db) return (w >> (idx - 1)) & 1;
        if (par != 0 && idx == db + 1) begin
            ones = $countones(w & ((1 << db) - 1));
            return (par == 1) ? (ones % 2) : (1 - (ones % 2));
        end
        return 1;
    endfunction

    // ---------------- reference model: queue + frame-in-flight ----------------
    int mq [3][16];
    int mhead [3];
    int mcnt  [3];
    int mword [3];
    int mt    [3];
    int mact  [3];

    task automatic model_reset(input int id);
        mhead[id] = 0; mcnt[id] = 0; mword[id] = 0; mt[id] = 0; mact[id] = 0;
    endtask

    task automatic model_step(input int id, input logic v, input int w);
        logic accept;
        accept = v && (mcnt[id] < DEPTH);
        if (mact[id] != 0 && mt[id] < flen(id) - 1) begin
            mt[id]++;
        end else if (mcnt[id] > 0) begin
            mword[id] = mq[id][mhead[id]];
            mhead[id] = (mhead[id] + 1) % 16;
            mcnt[id]--;
            mact[id] = 1;
            mt[id]   = 0;
        end else begin
            mact[id] = 0;
        end
        if (accept) begin
            mq[id][(mhead[id] + mcnt[id]) % 16] = w;
            mcnt[id]++;
        end
    endtask

    task automatic model_check(input int id, input logic l, input logic b, input int c, input logic r);
        int exp_line;
        exp_line = (mact[id] != 0) ? frame_bit(id, mword[id], mt[id] / C) : 1;
        check("line", id, int'(l), exp_line);
        check("busy", id, int'(b), mact[id]);
        check("count", id, c, mcnt[id]);
        check("ready", id, int'(r), (mcnt[id] < DEPTH) ? 1 : 0);
    endtask

    // Advance the model on every edge, then compare all outputs just after it.
    always begin
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) model_reset(i);
        end else begin
            model_step(0, v0, int'(din0));
            model_step(1, v1, int'(din1));
            model_step(2, v2, int'(din2));
        end
        #1;
        model_check(0, line0, busy0, int'(cnt0), rdy0);
        model_check(1, line1, busy1, int'(cnt1), rdy1);
        model_check(2, line2, busy2, int'(cnt2), rdy2);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int id, input logic v, input int w);
        case (id)
            0:       begin v0 = v; din0 = 8'(w); end
            1:       begin v1 = v; din1 = 7'(w); end
            default: begin v2 = v; din2 = 8'(w); end
        endcase
    endtask

    function automatic int get_line(input int id);
        case (id)
            0:       return int'(line0);
            1:       return int'(line1);
            default: return int'(line2);
        endcase
    endfunction

    function automatic int get_busy(input int id);
        case (id)
            0:       return int'(busy0);
            1:       return int'(busy1);
            default: return int'(busy2);
        endcase
    endfunction

    typedef struct {
        int          id;
        int          word;
        logic [15:0] pat;      // line levels in send order, first bit is MSB of nbits
        int          nbits;
        int          len;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int   cyc, target, bad, guard, ecount, k, maxcnt, id;
        int   acc_edge [6];
        int   words [6];
        logic rdy_s, rdy_after5, seen5, drain_ok;

        vecs[0] = '{0, 'hA5, 16'b0101001011,  10, 100};
        vecs[1] = '{0, 'h00, 16'b0000000001,  10, 100};
        vecs[2] = '{1, 'h41, 16'b01000001011, 11, 110};
        vecs[3] = '{1, 'h7F, 16'b01111111111, 11, 110};
        vecs[4] = '{2, 'hFF, 16'b01111111111, 11, 110};
        vecs[5] = '{2, 'h01, 16'b01000000001, 11, 110};
        words   = '{'h11, 'h22, 'h33, 'h44, 'h55, 'h66};
        acc_edge = '{0, 0, 0, 0, 0, 0};

        v0 = 0; v1 = 0; v2 = 0; din0 = 0; din1 = 0; din2 = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_line", 0, int'(line0), 1);
        check("reset_busy", 0, int'(busy0), 0);
        check("reset_count", 0, int'(cnt0), 0);
        check("reset_ready", 0, int'(rdy0), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle: nothing pushed for 1000 cycles.
        bad = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (line0 != 1 || line1 != 1 || line2 != 1 || busy0 || busy1 || busy2 ||
                !rdy0 || !rdy1 || !rdy2) bad++;
        end
        check("idle_1000", 0, bad, 0);
        $display("idle: 1000 cycles observed");

        // Known frames, one at a time.
        for (int i = 0; i < 6; i++) begin
            id = vecs[i].id;
            @(negedge clk); drive(id, 1'b1, vecs[i].word);
            @(posedge clk);
            @(negedge clk); drive(id, 1'b0, 0);
            @(posedge clk); #1;
            check("start_latency", id, get_line(id), 0);
            check("busy_rise", id, get_busy(id), 1);
            cyc = 0;
            for (int b = 0; b < vecs[i].nbits; b++) begin
                target = b * C + C / 2;
                while (cyc < target) begin @(posedge clk); cyc++; end
                #1;
                check("frame_bit", id, get_line(id), int'(vecs[i].pat[vecs[i].nbits - 1 - b]));
            end
            while (cyc < vecs[i].len - 1) begin @(posedge clk); cyc++; end
            #1;
            check("frame_last_cycle_busy", id, get_busy(id), 1);
            @(posedge clk); #1;
            check("frame_len_end", id, get_busy(id), 0);
            $display("frame: inst=%0d word=0x%0h bits=%0d", id, vecs[i].word, vecs[i].nbits);
        end

        // FIFO burst: six words offered back to back on the 8N1 instance.
        k = 0; ecount = 0; maxcnt = 0; guard = 0; rdy_after5 = 1'b1; seen5 = 1'b0;
        while (k < 6 && guard < 1000) begin
            @(negedge clk);
            drive(0, 1'b1, words[k]);
            rdy_s = rdy0;
            if (k == 5 && !seen5) begin rdy_after5 = rdy0; seen5 = 1'b1; end
            if (int'(cnt0) > maxcnt) maxcnt = int'(cnt0);
            @(posedge clk); ecount++; guard++;
            if (rdy_s) begin acc_edge[k] = ecount; k++; end
        end
        @(negedge clk); drive(0, 1'b0, 0);
        check("burst_accepts", 0, k, 6);
        check("burst_ready_drop", 0, int'(rdy_after5), 0);
        check("burst_max_count", 0, maxcnt, 4);
        check("burst_sixth_wait", 0, acc_edge[5] - acc_edge[0], 102);
        guard = 0;
        while (guard < 2000) begin
            @(posedge clk); ecount++; guard++; #1;
            if (!busy0) break;
        end
        check("burst_no_gaps", 0, ecount - acc_edge[0], 601);
        $display("burst: 6 words, sixth accepted %0d cycles after first", acc_edge[5] - acc_edge[0]);

        // Reset in the middle of the second queued frame's data bits.
        @(negedge clk); drive(0, 1'b1, 'h3C);
        @(negedge clk); drive(0, 1'b1, 'h00);
        @(negedge clk); drive(0, 1'b1, 'hC3);
        @(negedge clk); drive(0, 1'b0, 0);
        repeat (130) @(posedge clk);
        @(negedge clk);
        check("pre_reset_line", 0, int'(line0), 0);
        check("pre_reset_count", 0, int'(cnt0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_line", 0, int'(line0), 1);
        check("async_reset_busy", 0, int'(busy0), 0);
        check("async_reset_count", 0, int'(cnt0), 0);
        check("async_reset_ready", 0, int'(rdy0), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (line0 != 1 || busy0 || cnt0 != 0) bad++;
        end
        check("no_resume", 0, bad, 0);
        $display("reset: mid-frame abort, line idle afterwards");

        // Randomised traffic on all three instances; the model checks every cycle.
        for (int c = 0; c < 2400; c++) begin
            int thr;
            @(negedge clk);
            thr = (c < 1200) ? 40 : 2;
            drive(0, $urandom_range(0, thr - 1) == 0, int'($urandom));
            drive(1, $urandom_range(0, thr - 1) == 0, int'($urandom));
            drive(2, $urandom_range(0, thr - 1) == 0, int'($urandom));
        end
        @(negedge clk);
        drive(0, 1'b0, 0); drive(1, 1'b0, 0); drive(2, 1'b0, 0);
        guard = 0;
        while ((busy0 || busy1 || busy2 || cnt0 != 0 || cnt1 != 0 || cnt2 != 0) && guard < 3000) begin
            @(posedge clk); #1; guard++;
        end
        drain_ok = (guard < 3000);
        check("random_drain", 0, int'(drain_ok), 1);
        $display("random: 2400 cycles of traffic, drained after %0d cycles", guard);

        repeat (2) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
